// File: rtl/fir4csa_inv_u.sv
// Inverse of the 4-tap moving-sum FIR: a[n] = s[n] - s[n-1] + a[n-4].
// A sum stream that decodes outside [0, 2^w-1] latches a fault until clear or reset.

module fir4csa_cska #(
  parameter int W = 20,
  parameter int B = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);
  localparam int NB = (W + B - 1) / B;
  localparam int WP = NB * B;

  logic [WP-1:0] ap, bp, sp;

  assign ap = WP'(a);
  assign bp = WP'(b);

  // Ripple inside each block; a fully propagating block forwards its carry-in.
  always_comb begin
    logic c, cb, p, x;
    c  = cin;
    cb = 1'b0;
    p  = 1'b0;
    x  = 1'b0;
    sp = '0;
    for (int i = 0; i < NB; i++) begin
      cb = c;
      p  = 1'b1;
      for (int j = 0; j < B; j++) begin
        x            = ap[i*B+j] ^ bp[i*B+j];
        sp[i*B+j]    = x ^ c;
        c            = (ap[i*B+j] & bp[i*B+j]) | (x & c);
        p            = p & x;
      end
      if (p) c = cb;
    end
  end

  assign sum = sp[W-1:0];
endmodule

module fir4csa_inv_u #(
  parameter int w = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [w+1:0] s_in,
  output logic         out_valid,
  output logic [w-1:0] a_out,
  output logic         err
);
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t              state;
  logic [w+1:0]        s_prev;
  logic [3:0][w-1:0]   hist;
  logic [w+3:0]        diff, d;
  logic                ok;

  // Two's-complement subtract via inverted operand and carry-in.
  fir4csa_cska #(.W(w+4)) u_sub (
    .a   ({2'b00, s_in}),
    .b   (~{2'b00, s_prev}),
    .cin (1'b1),
    .sum (diff)
  );

  fir4csa_cska #(.W(w+4)) u_add (
    .a   (diff),
    .b   ({4'b0000, hist[3]}),
    .cin (1'b0),
    .sum (d)
  );

  assign ok = (d[w+3:w] == 4'b0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      s_prev    <= '0;
      hist      <= '0;
      out_valid <= 1'b0;
      a_out     <= '0;
      err       <= 1'b0;
    end else if (clear) begin
      state     <= RUN;
      s_prev    <= '0;
      hist      <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        RUN: begin
          if (in_valid) begin
            if (ok) begin
              a_out     <= d[w-1:0];
              out_valid <= 1'b1;
              hist      <= {hist[2:0], d[w-1:0]};
              s_prev    <= s_in;
            end else begin
              state <= FAULT;
              err   <= 1'b1;
            end
          end
        end
        FAULT: err <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fir4csa_inv_u.sv
// Bench for fir4csa_inv_u: directed scenarios with literal expectations plus
// a randomized stream checked every cycle against a queue-based decode model.

module tb_fir4csa_inv_u;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [W+1:0] s_in = '0;
  logic         out_valid;
  logic [W-1:0] a_out;
  logic         err;

  int checks = 0;
  int errors = 0;

  fir4csa_inv_u #(.w(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .s_in      (s_in),
    .out_valid (out_valid),
    .a_out     (a_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: keeps the decoded samples as a list.
  longint q[$];
  longint m_sprev = 0;
  bit     m_fault = 0;
  bit     exp_valid = 0;
  longint exp_a = 0;
  bit     exp_err = 0;

  always @(posedge clk or negedge reset) begin
    longint d, old4;
    if (!reset) begin
      q.delete(); m_sprev = 0; m_fault = 0;
      exp_valid = 0; exp_a = 0; exp_err = 0;
    end else if (clear) begin
      q.delete(); m_sprev = 0; m_fault = 0;
      exp_valid = 0; exp_err = 0;
    end else if (m_fault || !in_valid) begin
      exp_valid = 0;
    end else begin
      old4 = (q.size() >= 4) ? q[q.size()-4] : 0;
      d = longint'(s_in) - m_sprev + old4;
      if (d >= 0 && d < (longint'(1) << W)) begin
        q.push_back(d);
        if (q.size() > 8) void'(q.pop_front());
        exp_a = d; exp_valid = 1; m_sprev = longint'(s_in);
      end else begin
        m_fault = 1; exp_err = 1; exp_valid = 0;
      end
    end
  end

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_out_valid", longint'(out_valid), longint'(exp_valid));
    chk("model_err", longint'(err), longint'(exp_err));
    chk("model_a_out", longint'(a_out), exp_a);
  end

  task automatic cyc(input logic v, input longint s, input logic c);
    in_valid = v; s_in = (W+2)'(s); clear = c;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic expect_out(string name, input logic v, input longint a, input logic e);
    chk({name, "_valid"}, longint'(out_valid), longint'(v));
    if (v) chk({name, "_a"}, longint'(a_out), a);
    chk({name, "_err"}, longint'(err), longint'(e));
  endtask

  initial begin
    longint seq1[5] = '{1, 3, 6, 10, 14};
    longint fs[5]   = '{'hFFFF, 'h1FFFE, 'h2FFFD, 'h3FFFC, 'h3FFFC};
    longint an, old4, s;

    #2;
    expect_out("reset", 1'b0, 0, 1'b0);
    chk("reset_a_out", longint'(a_out), 0);
    @(posedge clk); #1; reset = 1'b1;
    cyc(0, 0, 0);

    foreach (seq1[i]) begin
      cyc(1, seq1[i], 0);
      expect_out("loopback", 1'b1, i + 1, 1'b0);
    end
    cyc(0, 0, 0);
    expect_out("loopback_idle", 1'b0, 0, 1'b0);

    cyc(0, 0, 1);
    foreach (fs[i]) begin
      cyc(1, fs[i], 0);
      expect_out("fullscale", 1'b1, 'hFFFF, 1'b0);
    end

    cyc(0, 0, 1);
    cyc(1, 5, 0);
    expect_out("neg_first", 1'b1, 5, 1'b0);
    cyc(1, 2, 0);
    expect_out("neg_fault", 1'b0, 0, 1'b1);
    chk("neg_a_hold", longint'(a_out), 5);
    cyc(1, 9, 0);
    expect_out("neg_ignored", 1'b0, 0, 1'b1);

    cyc(0, 0, 1);
    expect_out("clear_err", 1'b0, 0, 1'b0);
    cyc(1, 'h10000, 0);
    expect_out("ovf_fault", 1'b0, 0, 1'b1);
    cyc(0, 0, 1);
    cyc(1, 7, 0);
    expect_out("ovf_recover", 1'b1, 7, 1'b0);

    cyc(0, 0, 1);
    cyc(1, 1, 0);
    expect_out("gap_first", 1'b1, 1, 1'b0);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 3, 0);
    expect_out("gap_second", 1'b1, 2, 1'b0);
    cyc(1, 100, 1);
    expect_out("clear_prio", 1'b0, 0, 1'b0);
    cyc(1, 9, 0);
    expect_out("after_clear", 1'b1, 9, 1'b0);

    // Randomized stream: mostly well-formed sums, some corrupt, some clears.
    cyc(0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if ((m_fault && r < 20) || r < 2) begin
        cyc($urandom_range(0, 1), $urandom, 1);
      end else if (r < 27) begin
        cyc(0, 0, 0);
      end else if (r < 32) begin
        cyc(1, $urandom_range(0, (1 << (W+2)) - 1), 0);
      end else begin
        an   = (r < 40) ? ((r & 1) ? 'hFFFF : 0) : $urandom_range(0, (1 << W) - 1);
        old4 = (q.size() >= 4) ? q[q.size()-4] : 0;
        s    = an + m_sprev - old4;
        if (s < 0 || s >= (longint'(1) << (W+2))) s = $urandom_range(0, (1 << (W+2)) - 1);
        cyc(1, s, 0);
      end
    end

    // Asynchronous reset between edges while streaming.
    cyc(0, 0, 1);
    cyc(1, 'h1234, 0);
    expect_out("pre_areset", 1'b1, 'h1234, 1'b0);
    in_valid = 1'b1; s_in = 'h5000;
    #1 reset = 1'b0;
    #1;
    expect_out("areset", 1'b0, 0, 1'b0);
    chk("areset_a_out", longint'(a_out), 0);
    in_valid = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    cyc(1, 4, 0);
    expect_out("post_areset", 1'b1, 4, 1'b0);
    cyc(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir4csa_inv_u.md
# fir4csa_inv_u

Inverse (reconstruction) filter for the 4-tap unity-coefficient moving-sum FIR. It consumes the `w+2`-bit sum stream produced by the forward filter and recovers the original `w`-bit input samples with the recursion a[n] = s[n] − s[n−1] + a[n−4]. It also detects sum streams that no valid input sequence could have produced, and latches a fault until cleared. It sits on the receive side of a moving-sum link, or in the verification loop-back path behind the forward FIR.

## Interface
- `w`, default 16, width of the reconstructed sample; the sum input is `w+2` bits.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- `clear`  in  1  synchronous restart: zeroes history, leaves FAULT, clears `err`.
- `in_valid`  in  1  `s_in` holds a new sum sample this cycle.
- `s_in`  in  `w+2`  unsigned moving-sum sample.
- `out_valid`  out  1  `a_out` holds a new reconstructed sample (one-cycle pulse per sample).
- `a_out`  out  `w`  unsigned reconstructed sample.
- `err`  out  1  sticky fault flag.

## Operation
- State: `s_prev` (`w+2` bits), history `h0..h3` (`w` bits each; `h0` is the newest reconstructed sample, `h3` is a[n−4]), and a 1-bit FSM {RUN, FAULT}.
- After reset or `clear`, all history is 0. This matches the forward filter's zero-filled delay line, so the first sample decodes as a[0] = s[0].
- RUN, `in_valid`=1:
  - Compute d = s_in − s_prev + h3 in `w+4`-bit signed arithmetic. Operands are zero-extended; no intermediate truncation.
  - If 0 ≤ d ≤ 2^w−1: `a_out`←d[w−1:0] and `out_valid`←1. Then `h3`←`h2`, `h2`←`h1`, `h1`←`h0`, `h0`←d[w−1:0], and `s_prev`←s_in.
  - Otherwise: FSM→FAULT, `err`←1, `out_valid`←0. History, `s_prev` and `a_out` hold their values.
- RUN, `in_valid`=0: `out_valid`←0 and all history holds. Gaps of any length between samples are allowed and do not affect the result.
- FAULT: `in_valid` is ignored, `out_valid` stays 0, `err` stays 1, and all state holds. Only `clear` or `reset` exits FAULT.
- `clear`=1 takes priority over `in_valid`: the input sample that cycle is dropped. Next state is RUN with zero history, `s_prev`=0, `err`=0, `out_valid`=0. `a_out` holds its value.
- There is no backpressure. The block accepts one sample per cycle indefinitely.

## Timing
- Reset values: `out_valid`=0, `a_out`=0, `err`=0, FSM=RUN, `s_prev`=0, `h0..h3`=0.
- `reset` assertion clears all state asynchronously, including mid-stream and in FAULT. Deassertion is synchronised externally; the first edge after release is a normal edge.
- Latency: `s_in` sampled with `in_valid` at edge k appears as `a_out` with `out_valid`=1 after edge k. Latency is 1 cycle, throughput is 1 sample per cycle.
- `err` rises after the same edge at which the bad sample is sampled, and `out_valid` is 0 in that cycle.
- `clear` takes effect at the edge: `err` falls and `out_valid`=0 after that edge. A sample at edge k+1 is then decoded as a first sample.
- Datapath is a single registered stage of subtract plus add. Use the team's carry-skip adder cells for the `w+4`-bit operations.

## Test plan
- Forward loop-back, w=16: send s = 1, 3, 6, 10, 14 on consecutive cycles → `a_out` = 1, 2, 3, 4, 5, each `out_valid` one cycle after its input, `err`=0.
- Full-scale: send s = 0xFFFF, 0x1FFFE, 0x2FFFD, 0x3FFFC, 0x3FFFC → `a_out` = 0xFFFF on all five outputs, `err`=0. This checks that the w+4 width does not wrap.
- Negative fault: after reset send s=5 then s=2 (d=−3) → `a_out`=5, then `err`=1 and no `out_valid`. Further valid samples produce nothing.
- Overflow fault: after reset send s=0x10000 (d=65536) → `err`=1 and `out_valid`=0. Then pulse `clear`, send s=7 → `err`=0 and `a_out`=7.
- Gaps and clear priority: send s=1, idle 5 cycles, send s=3 → `a_out`=1 then 2. Assert `clear` together with `in_valid`, s=100 → no output. Next sample s=9 → `a_out`=9.
- Async reset mid-stream: drop `reset` between edges while streaming → `out_valid`, `a_out` and `err` go to 0 before the next edge. After release, s=4 → `a_out`=4.
